// File: rtl/mantenimiento_pkg.sv
// ============================================================================
// | Package : mantenimiento_pkg                                              |
// | Shared types and sizing helper for the maintenance-count next-state logic|
// | Revision: 1.0                                                            |
// ============================================================================
`default_nettype none

package mantenimiento_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FILTRO   = 3'd1,
        SERVICIO = 3'd2,
        COMMIT   = 3'd3,
        ESPERA   = 3'd4
    } estado_fsm_t;

    typedef logic [7:0] cuenta_t;

    // Phase counter must hold the longer of the two phase lengths.
    function automatic int unsigned cnt_w_f(input int unsigned a, input int unsigned b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

    localparam int unsigned CNT_W_DEF = cnt_w_f(4, 8);

endpackage

`default_nettype wire

// File: rtl/sincronizador.sv
// ============================================================================
// | Module  : sincronizador                                                  |
// | Two-flop synchroniser for an asynchronous single-bit input               |
// | Revision: 1.0                                                            |
// ============================================================================
`default_nettype none

module sincronizador (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

`default_nettype wire

// File: rtl/logica_mantenimiento.sv
// ============================================================================
// | Module  : logica_mantenimiento                                           |
// | Debounced service sequence and saturating next-count for the register   |
// | Revision: 1.0                                                            |
// ============================================================================
`default_nettype none

module logica_mantenimiento
    import mantenimiento_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned SERVICE_CYCLES  = 8,
    parameter cuenta_t     MAX_MANT        = 8'hFF,
    parameter cuenta_t     ALARM_THRESH    = 8'd10
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    btn_mant,
    input  logic    btn_clr,
    input  cuenta_t estado_actual,
    output cuenta_t estado,
    output logic    servicio,
    output logic    listo,
    output logic    alarma
);

    localparam int unsigned      CNT_W    = cnt_w_f(DEBOUNCE_CYCLES, SERVICE_CYCLES);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SRV_LAST = CNT_W'(SERVICE_CYCLES - 1);

    estado_fsm_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             btn_s;
    logic [8:0]       suma;

    sincronizador u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_mant),
        .q     (btn_s)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (btn_s) state_d = FILTRO;
            FILTRO: begin
                if (!btn_s)                 state_d = IDLE;
                else if (cnt_q == DEB_LAST) state_d = SERVICIO;
            end
            SERVICIO: if (cnt_q == SRV_LAST) state_d = COMMIT;
            COMMIT:   state_d = ESPERA;
            ESPERA:   if (!btn_s) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        if (btn_clr) state_d = IDLE;
    end

    // Counter restarts on every state entry and only advances in timed phases.
    always_comb begin
        cnt_d = cnt_q;
        if (btn_clr || (state_d != state_q)) begin
            cnt_d = '0;
        end else if (((state_q == FILTRO) || (state_q == SERVICIO)) && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign suma = {1'b0, estado_actual} + 9'd1;

    always_comb begin
        estado   = estado_actual;
        listo    = 1'b0;
        servicio = (state_q == SERVICIO);
        if (state_q == COMMIT) begin
            listo  = 1'b1;
            estado = (suma > {1'b0, MAX_MANT}) ? MAX_MANT : suma[7:0];
        end
        if (btn_clr || !reset) begin
            estado = 8'h00;
            listo  = 1'b0;
        end
        if (!reset) servicio = 1'b0;
    end

    assign alarma = (estado_actual >= ALARM_THRESH);

endmodule

`default_nettype wire
